// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch front end: fetch FSM state
// encoding, instruction size and the default reset fetch address.
package cpu_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } fetch_state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// Fetch-side bundle: pipeline control inputs, instruction-memory handshake
// and pipeline-register flushes. With FETCH_STATS_EN defined it also carries
// the redirect/squash statistics counters.
interface fetch_redirect_unit_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              branchTaken;
    logic [ADDR_W-1:0] branchTarget;
    logic              jump;
    logic [ADDR_W-1:0] jumpTarget;
    logic              imemReady;
    logic [ADDR_W-1:0] pc;
    logic              imemReq;
    logic              fetchValid;
    logic              flushIFID;
    logic              flushIDEX;
`ifdef FETCH_STATS_EN
    logic [31:0]       redirectCount;
    logic [31:0]       squashCount;
`endif

    // Fetch unit side.
    modport master (
        input  stall, branchTaken, branchTarget, jump, jumpTarget, imemReady,
`ifdef FETCH_STATS_EN
        output redirectCount, squashCount,
`endif
        output pc, imemReq, fetchValid, flushIFID, flushIDEX
    );

    // Pipeline / memory environment side.
    modport slave (
        output stall, branchTaken, branchTarget, jump, jumpTarget, imemReady,
`ifdef FETCH_STATS_EN
        input  redirectCount, squashCount,
`endif
        input  pc, imemReq, fetchValid, flushIFID, flushIDEX
    );

endinterface

// File: rtl/fetch_redirect_unit_redirect_latch.sv
// redirect_latch: remembers a redirect that arrived while an instruction
// fetch was outstanding and unready. A later load overwrites the stored
// target (younger correction wins); completion of the fetch clears it.
module redirect_latch #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] target,
    input  logic              clear,
    output logic              pendValid,
    output logic [ADDR_W-1:0] pendTarget
);

    logic              valid_reg;
    logic [ADDR_W-1:0] target_reg;

    // Load/overwrite takes priority; otherwise completion drops the entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg  <= 1'b0;
            target_reg <= '0;
        end else if (load) begin
            valid_reg  <= 1'b1;
            target_reg <= target;
        end else if (clear) begin
            valid_reg  <= 1'b0;
        end
    end

    assign pendValid  = valid_reg;
    assign pendTarget = target_reg;

endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: owns the PC and the instruction-memory handshake.
// Applies branch/jump redirects (branch beats jump, any redirect beats stall),
// defers redirects that arrive during an unready fetch until it completes and
// squashes that stale fetch, and drives the IF/ID and ID/EX flushes.
// Optional feature: define FETCH_STATS_EN to add saturating redirectCount
// and squashCount outputs.
module fetch_redirect_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_redirect_unit_if.master  bus
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              imem_req;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_target;
    logic              complete;
    logic              fetch_valid;
    logic              pend_load;
    logic              pendValid;
    logic [ADDR_W-1:0] pendTarget;

    // The older EX-stage branch squashes a younger ID-stage jump.
    assign redirect        = bus.branchTaken | bus.jump;
    assign redirect_target = bus.branchTaken ? bus.branchTarget : bus.jumpTarget;
    assign complete        = imem_req & bus.imemReady;
    assign fetch_valid     = complete & ~bus.stall & ~pendValid & ~redirect;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= BOOT;
        else     state_reg <= state_next;
    end

    // FSM next state and request output.
    always_comb begin
        state_next = state_reg;
        imem_req   = 1'b0;
        case (state_reg)
            BOOT: begin
                state_next = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (!bus.imemReady) state_next = WAIT;
            end
            WAIT: begin
                imem_req = 1'b1;
                if (bus.imemReady) state_next = FETCH;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // PC selection: immediate redirect, deferred redirect, deferred target
    // on completion, sequential advance, else hold (covers stall re-issue).
    always_comb begin
        pc_next   = pc_reg;
        pend_load = 1'b0;
        if (redirect && (state_reg == BOOT || bus.imemReady)) begin
            pc_next = redirect_target;
        end else if (redirect) begin
            pend_load = 1'b1;
        end else if (complete && pendValid) begin
            pc_next = pendTarget;
        end else if (fetch_valid) begin
            pc_next = pc_reg + ADDR_W'(INSTR_BYTES);
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_reg <= RESET_PC;
        else     pc_reg <= pc_next;
    end

    redirect_latch #(
        .ADDR_W (ADDR_W)
    ) u_redirect_latch (
        .clk        (clk),
        .rst        (rst),
        .load       (pend_load),
        .target     (redirect_target),
        .clear      (complete),
        .pendValid  (pendValid),
        .pendTarget (pendTarget)
    );

    assign bus.pc         = pc_reg;
    assign bus.imemReq    = imem_req;
    assign bus.fetchValid = fetch_valid;
    assign bus.flushIFID  = redirect;
    assign bus.flushIDEX  = bus.branchTaken;

`ifdef FETCH_STATS_EN
    logic [31:0] redirect_count_reg;
    logic [31:0] squash_count_reg;

    // Saturating statistics: redirect cycles and completed-but-squashed fetches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_count_reg <= '0;
            squash_count_reg   <= '0;
        end else begin
            if (redirect)
                redirect_count_reg <= sat_inc(redirect_count_reg);
            if (complete && !fetch_valid)
                squash_count_reg <= sat_inc(squash_count_reg);
        end
    end

    assign bus.redirectCount = redirect_count_reg;
    assign bus.squashCount   = squash_count_reg;
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench for fetch_redirect_unit: a per-cycle vector table of
// inputs and expected outputs starting from reset release, followed by a
// hand-written asynchronous reset in the middle of a waiting fetch.
module tb_fetch_redirect_unit;

    logic clk;
    logic rst;

    fetch_redirect_unit_if #(.ADDR_W(32)) bus ();

    fetch_redirect_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        bt;
        logic [31:0] btgt;
        logic        jmp;
        logic [31:0] jtgt;
        logic        rdy;
        logic [31:0] pc;
        logic        req;
        logic        fv;
        logic        fifid;
        logic        fidex;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vecs [NVEC];

    int total_checks;
    int passed_checks;

    function automatic vec_t mk(input logic stall, input logic bt, input logic [31:0] btgt,
                                input logic jmp, input logic [31:0] jtgt, input logic rdy,
                                input logic [31:0] pc, input logic req, input logic fv,
                                input logic fifid, input logic fidex);
        vec_t v;
        v.stall = stall; v.bt = bt; v.btgt = btgt; v.jmp = jmp; v.jtgt = jtgt; v.rdy = rdy;
        v.pc = pc; v.req = req; v.fv = fv; v.fifid = fifid; v.fidex = fidex;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.stall        = v.stall;
        bus.branchTaken  = v.bt;
        bus.branchTarget = v.btgt;
        bus.jump         = v.jmp;
        bus.jumpTarget   = v.jtgt;
        bus.imemReady    = v.rdy;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;

        //           stall bt btgt          jmp jtgt          rdy  pc            req fv fIFID fIDEX
        vecs[0]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0000, 0, 0, 0, 0); // BOOT
        vecs[1]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0000, 1, 1, 0, 0);
        vecs[2]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0004, 1, 1, 0, 0);
        vecs[3]  = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0008, 1, 0, 0, 0); // stall
        vecs[4]  = mk(1, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0008, 1, 0, 0, 0); // stall
        vecs[5]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0008, 1, 1, 0, 0);
        vecs[6]  = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_000C, 1, 1, 0, 0);
        vecs[7]  = mk(0, 1, 32'h80,        0, 32'h0,         1, 32'h0000_0010, 1, 0, 1, 1); // branch
        vecs[8]  = mk(0, 1, 32'h20,        1, 32'h40,        1, 32'h0000_0080, 1, 0, 1, 1); // branch+jump
        vecs[9]  = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0020, 1, 0, 0, 0); // wait 1
        vecs[10] = mk(0, 1, 32'h100,       0, 32'h0,         0, 32'h0000_0020, 1, 0, 1, 1); // wait 2 + branch
        vecs[11] = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0020, 1, 0, 0, 0); // wait 3
        vecs[12] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0020, 1, 0, 0, 0); // squashed
        vecs[13] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0100, 1, 1, 0, 0);
        vecs[14] = mk(0, 0, 32'h0,         1, 32'h200,       1, 32'h0000_0104, 1, 0, 1, 0); // jump
        vecs[15] = mk(0, 0, 32'h0,         1, 32'h300,       0, 32'h0000_0200, 1, 0, 1, 0); // held jump
        vecs[16] = mk(0, 1, 32'h400,       0, 32'h0,         1, 32'h0000_0200, 1, 0, 1, 1); // new beats pend
        vecs[17] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0400, 1, 1, 0, 0);
        vecs[18] = mk(0, 0, 32'h0,         0, 32'h0,         0, 32'h0000_0404, 1, 0, 0, 0);
        vecs[19] = mk(0, 0, 32'h0,         1, 32'h500,       0, 32'h0000_0404, 1, 0, 1, 0); // pend load
        vecs[20] = mk(0, 1, 32'h600,       0, 32'h0,         0, 32'h0000_0404, 1, 0, 1, 1); // overwrite
        vecs[21] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0404, 1, 0, 0, 0); // squashed
        vecs[22] = mk(0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 32'h0000_0600, 1, 0, 1, 0);
        vecs[23] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC, 1, 1, 0, 0); // wrap
        vecs[24] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0000, 1, 1, 0, 0);
        vecs[25] = mk(1, 0, 32'h0,         1, 32'h80,        1, 32'h0000_0004, 1, 0, 1, 0); // jump beats stall
        vecs[26] = mk(0, 0, 32'h0,         0, 32'h0,         1, 32'h0000_0080, 1, 1, 0, 0);

        drive(mk(0, 0, 32'h0, 0, 32'h0, 1, 32'h0, 0, 0, 0, 0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc",  bus.pc,         32'h0);
        chk("reset_req", 32'(bus.imemReq),    32'h0);
        chk("reset_fv",  32'(bus.fetchValid), 32'h0);
`ifdef FETCH_STATS_EN
        chk("reset_redirect_count", bus.redirectCount, 32'h0);
        chk("reset_squash_count",   bus.squashCount,   32'h0);
`endif

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            #1;
            $display("vec %0d: pc=0x%08h req=%0b fv=%0b flushIFID=%0b flushIDEX=%0b",
                     i, bus.pc, bus.imemReq, bus.fetchValid, bus.flushIFID, bus.flushIDEX);
            chk($sformatf("v%0d_pc", i),    bus.pc,                 vecs[i].pc);
            chk($sformatf("v%0d_req", i),   32'(bus.imemReq),       32'(vecs[i].req));
            chk($sformatf("v%0d_fv", i),    32'(bus.fetchValid),    32'(vecs[i].fv));
            chk($sformatf("v%0d_fifid", i), 32'(bus.flushIFID),     32'(vecs[i].fifid));
            chk($sformatf("v%0d_fidex", i), 32'(bus.flushIDEX),     32'(vecs[i].fidex));
            @(negedge clk);
        end

`ifdef FETCH_STATS_EN
        // Redirect cycles: vectors 7,8,10,14,15,16,19,20,22,25.
        // Completed fetches not kept: vectors 3,4,7,8,12,14,16,21,22,25.
        chk("redirect_count", bus.redirectCount, 32'd10);
        chk("squash_count",   bus.squashCount,   32'd10);
`endif

        // Reset asserted mid-cycle while a fetch is waiting on memory.
        drive(mk(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("wait_pc",  bus.pc,            32'h0000_0084);
        chk("wait_req", 32'(bus.imemReq),  32'h1);
        #2;
        bus.jump = 1'b1;
        rst = 1'b1;
        #1;
        $display("async reset: pc=0x%08h req=%0b flushIFID=%0b", bus.pc, bus.imemReq, bus.flushIFID);
        chk("async_rst_pc",    bus.pc,              32'h0);
        chk("async_rst_req",   32'(bus.imemReq),    32'h0);
        chk("async_rst_fv",    32'(bus.fetchValid), 32'h0);
        chk("async_rst_flush", 32'(bus.flushIFID),  32'h1);
`ifdef FETCH_STATS_EN
        chk("async_rst_redirect_count", bus.redirectCount, 32'h0);
        chk("async_rst_squash_count",   bus.squashCount,   32'h0);
`endif
        @(negedge clk);
        bus.jump = 1'b0;
        bus.imemReady = 1'b1;
        rst = 1'b0;
        #1;
        chk("post_rst_boot_req", 32'(bus.imemReq), 32'h0);
        @(negedge clk);
        #1;
        chk("post_rst_fetch_req", 32'(bus.imemReq), 32'h1);
        chk("post_rst_fetch_pc",  bus.pc,           32'h0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
